// File: rtl/sprite_eval_if.sv
// OAM-side bus of the sprite evaluator: primary OAM read port plus the
// secondary OAM read port used by the sprite fetch stage.
interface sprite_eval_if;
    logic [7:0] oam_addr;
    logic [7:0] oam_data;
    logic       eval_active;
    logic [4:0] sec_rd_addr;
    logic [7:0] sec_rd_data;

    modport master (
        output oam_addr,
        output eval_active,
        input  oam_data,
        input  sec_rd_addr,
        output sec_rd_data
    );

    modport slave (
        input  oam_addr,
        input  eval_active,
        output oam_data,
        output sec_rd_addr,
        input  sec_rd_data
    );
endinterface

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM and
// copies up to MAX_SPR in-range sprites, flagging overflow and sprite-0 presence.
module sprite_eval #(
    parameter int unsigned MAX_SPR  = 8,
    parameter int unsigned NUM_SPR  = 64,
    parameter int unsigned LAST_VIS = 239,
    parameter int unsigned PRE_LINE = 261
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en_i,
    input  logic [8:0]    row_i,
    input  logic [8:0]    col_i,
    input  logic          render_en_i,
    input  logic          spr_16_i,
    sprite_eval_if.master bus,
    output logic [3:0]    spr_count_o,
    output logic          spr0_in_line_o,
    output logic          spr_overflow_o,
    output logic          eval_done_o
);
    localparam int unsigned SEC_BYTES = 4 * MAX_SPR;
    localparam int unsigned SEC_AW    = $clog2(SEC_BYTES);
    localparam int unsigned IDX_W     = $clog2(NUM_SPR);
    localparam int unsigned SLOT_W    = $clog2(MAX_SPR + 1);

    localparam logic [8:0]        LAST_ROW  = 9'(LAST_VIS);
    localparam logic [8:0]        PRE_ROW   = 9'(PRE_LINE);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SPR - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_SPR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_EVAL_Y,
        S_COPY,
        S_OVF_CHK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    m_q, m_d;
    logic [SLOT_W-1:0]   n_q, n_d;
    logic [1:0]          k_q, k_d;
    logic                spr0_q, spr0_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          sec_q [SEC_BYTES];

    logic                sec_we;
    logic [SEC_AW-1:0]   sec_wa;
    logic [7:0]          sec_wd;

    logic                line_active;
    logic                last_idx;
    logic [8:0]          diff;
    logic [8:0]          height;
    logic                hit;

    assign line_active = render_en_i && (row_i <= LAST_ROW);
    assign last_idx    = (m_q == LAST_IDX);

    // Borrow out of the 9-bit subtraction marks sprites starting below this row.
    assign diff   = {1'b0, row_i[7:0]} - {1'b0, bus.oam_data};
    assign height = spr_16_i ? 9'd16 : 9'd8;
    assign hit    = !diff[8] && (diff < height);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        spr0_d  = spr0_q;
        ovf_d   = ovf_q;
        sec_we  = 1'b0;
        sec_wa  = '0;
        sec_wd  = '1;

        case (state_q)
            S_IDLE: begin
                if (line_active && col_i == 9'd1) begin
                    state_d = S_CLEAR;
                    n_d     = '0;
                    spr0_d  = 1'b0;
                    sec_we  = 1'b1;
                    sec_wa  = '0;
                end
            end
            S_CLEAR: begin
                if (col_i >= 9'd1 && col_i <= 9'd32) begin
                    sec_we = 1'b1;
                    sec_wa = SEC_AW'(col_i - 9'd1);
                end
                if (col_i >= 9'd32) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (col_i == 9'd64) begin
                    state_d = S_EVAL_Y;
                    m_d     = '0;
                    n_d     = '0;
                    k_d     = '0;
                end
            end
            S_EVAL_Y: begin
                if (hit) begin
                    sec_we  = 1'b1;
                    sec_wa  = SEC_AW'({n_q, 2'b00});
                    sec_wd  = bus.oam_data;
                    k_d     = 2'd1;
                    state_d = S_COPY;
                end else if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    m_d = m_q + 1'b1;
                end
            end
            S_COPY: begin
                sec_we = 1'b1;
                sec_wa = SEC_AW'({n_q, k_q});
                sec_wd = bus.oam_data;
                if (m_q == '0) begin
                    spr0_d = 1'b1;
                end
                if (k_q == 2'd3) begin
                    n_d = n_q + 1'b1;
                    if (last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        m_d     = m_q + 1'b1;
                        state_d = (n_q == LAST_SLOT) ? S_OVF_CHK : S_EVAL_Y;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OVF_CHK: begin
                if (hit) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    m_d = m_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Past the evaluation window the scan is cut short without further writes.
        if (col_i >= 9'd257 && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_DONE;
            sec_we  = 1'b0;
            m_d     = m_q;
            n_d     = n_q;
            k_d     = k_q;
            spr0_d  = spr0_q;
            ovf_d   = ovf_q;
        end

        // Losing the line abandons the scan silently, keeping partial results.
        if (!line_active && state_q != S_IDLE) begin
            state_d = S_IDLE;
            sec_we  = 1'b0;
            m_d     = m_q;
            n_d     = n_q;
            k_d     = k_q;
            spr0_d  = spr0_q;
            ovf_d   = ovf_q;
        end

        if (row_i == PRE_ROW && col_i == 9'd1) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            spr0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            spr0_q  <= spr0_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SEC_BYTES; i++) begin
                sec_q[i] <= '1;
            end
        end else if (clk_en_i && sec_we) begin
            sec_q[sec_wa] <= sec_wd;
        end
    end

    always_comb begin
        bus.eval_active = 1'b0;
        bus.oam_addr    = '0;
        eval_done_o     = 1'b0;
        case (state_q)
            S_EVAL_Y, S_OVF_CHK: begin
                bus.eval_active = 1'b1;
                bus.oam_addr    = 8'({m_q, 2'b00});
            end
            S_COPY: begin
                bus.eval_active = 1'b1;
                bus.oam_addr    = 8'({m_q, k_q});
            end
            S_DONE: begin
                eval_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.sec_rd_data = sec_q[bus.sec_rd_addr];
    assign spr_count_o     = 4'(n_q);
    assign spr0_in_line_o  = spr0_q;
    assign spr_overflow_o  = ovf_q;
endmodule

// File: tb/tb_sprite_eval.sv
// Self-checking bench for sprite_eval: directed scenarios plus randomized
// scanlines compared against a per-line behavioural model.
module tb_sprite_eval;
    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [8:0] row;
    logic [8:0] col;
    logic       render_en;
    logic       spr_16;
    logic [3:0] spr_count;
    logic       spr0_in_line;
    logic       spr_overflow;
    logic       eval_done;
    logic [7:0] oam [256];

    sprite_eval_if bus ();
    assign bus.oam_data = oam[bus.oam_addr];

    sprite_eval #(
        .MAX_SPR (8),
        .NUM_SPR (64),
        .LAST_VIS(239),
        .PRE_LINE(261)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en_i      (clk_en),
        .row_i         (row),
        .col_i         (col),
        .render_en_i   (render_en),
        .spr_16_i      (spr_16),
        .bus           (bus),
        .spr_count_o   (spr_count),
        .spr0_in_line_o(spr0_in_line),
        .spr_overflow_o(spr_overflow),
        .eval_done_o   (eval_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected line results, derived from the sprite rules
    logic [7:0] m_sec [32];
    int         m_cnt;
    bit         m_spr0;
    bit         m_ovf;
    int         exp_done;

    int         obs_done_dot;
    int         obs_done_cnt;
    int         obs_act_cnt;
    logic [7:0] obs_sec [32];

    function automatic void model_line(int r, bit rend, bit s16);
        int h = s16 ? 16 : 8;
        int idx[$];
        int ticks;
        exp_done = -1;
        if (rend && r <= 239) begin
            for (int i = 0; i < 64; i++) begin
                int y = oam[4*i];
                if (r >= y && r - y < h) idx.push_back(i);
            end
            foreach (m_sec[b]) m_sec[b] = 8'hFF;
            m_cnt = (idx.size() > 8) ? 8 : idx.size();
            for (int s = 0; s < m_cnt; s++)
                for (int b = 0; b < 4; b++)
                    m_sec[4*s+b] = oam[4*idx[s]+b];
            m_spr0 = (idx.size() > 0 && idx[0] == 0);
            if (idx.size() < 8) ticks = 64 + 3 * idx.size();
            else ticks = idx[7] + 25 + ((idx.size() > 8) ? idx[8] - idx[7] : 63 - idx[7]);
            if (idx.size() > 8) m_ovf = 1'b1;
            exp_done = 65 + ticks;
        end
        if (r == 261) m_ovf = 1'b0;
    endfunction

    task automatic run_line(input int r, input bit rend, input bit s16, input int last_col, input int drop_col);
        obs_done_dot = -1;
        obs_done_cnt = 0;
        obs_act_cnt  = 0;
        for (int c = 0; c <= last_col; c++) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                clk_en = 1'b0;
            end
            @(negedge clk);
            row       = 9'(r);
            col       = 9'(c);
            spr_16    = s16;
            render_en = (drop_col >= 0 && c >= drop_col) ? 1'b0 : rend;
            clk_en    = 1'b1;
            #1;
            if (bus.eval_active === 1'b1) obs_act_cnt++;
            if (eval_done === 1'b1) begin
                if (obs_done_dot < 0) obs_done_dot = c;
                obs_done_cnt++;
            end
        end
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    task automatic read_sec();
        for (int i = 0; i < 32; i++) begin
            bus.sec_rd_addr = 5'(i);
            #1;
            obs_sec[i] = bus.sec_rd_data;
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; render_en = 1'b0; spr_16 = 1'b0;
        row = '0; col = '0; bus.sec_rd_addr = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (spr_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", spr_count); end
        n_cmp++; if (spr0_in_line !== 1'b0) begin n_err++; $display("FAIL reset_spr0: got %b expected 0", spr0_in_line); end
        n_cmp++; if (spr_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", spr_overflow); end
        n_cmp++; if (eval_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", eval_done); end
        n_cmp++; if (bus.eval_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b expected 0", bus.eval_active); end
        n_cmp++; if (bus.oam_addr !== 8'd0) begin n_err++; $display("FAIL reset_oam_addr: got %h expected 00", bus.oam_addr); end
        read_sec();
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (obs_sec[i] !== 8'hFF) begin n_err++; $display("FAIL reset_sec[%0d]: got %h expected ff", i, obs_sec[i]); end
        end
        rst = 1'b0;
        foreach (m_sec[b]) m_sec[b] = 8'hFF;
        m_cnt = 0; m_spr0 = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic test_all_miss();
        clear_oam();
        model_line(10, 1'b1, 1'b0);
        run_line(10, 1'b1, 1'b0, 340, -1);
        read_sec();
        n_cmp++; if (obs_done_dot != exp_done) begin n_err++; $display("FAIL miss_done_dot: got %0d expected %0d", obs_done_dot, exp_done); end
        n_cmp++; if (obs_done_cnt != 1) begin n_err++; $display("FAIL miss_done_pulses: got %0d expected 1", obs_done_cnt); end
        n_cmp++; if (obs_act_cnt != exp_done - 65) begin n_err++; $display("FAIL miss_active_dots: got %0d expected %0d", obs_act_cnt, exp_done - 65); end
        n_cmp++; if (spr_count !== 4'(m_cnt)) begin n_err++; $display("FAIL miss_count: got %0d expected %0d", spr_count, m_cnt); end
        n_cmp++; if (spr_overflow !== m_ovf) begin n_err++; $display("FAIL miss_ovf: got %b expected %b", spr_overflow, m_ovf); end
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (obs_sec[i] !== m_sec[i]) begin n_err++; $display("FAIL miss_sec[%0d]: got %h expected %h", i, obs_sec[i], m_sec[i]); end
        end
    endtask

    task automatic test_sprite0();
        logic [7:0] want [4];
        want = '{8'h0A, 8'h21, 8'h03, 8'h40};
        clear_oam();
        for (int b = 0; b < 4; b++) oam[b] = want[b];
        model_line(12, 1'b1, 1'b0);
        run_line(12, 1'b1, 1'b0, 340, -1);
        read_sec();
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (obs_sec[b] !== want[b]) begin n_err++; $display("FAIL spr0_byte[%0d]: got %h expected %h", b, obs_sec[b], want[b]); end
        end
        for (int i = 4; i < 32; i++) begin
            n_cmp++; if (obs_sec[i] !== m_sec[i]) begin n_err++; $display("FAIL spr0_sec[%0d]: got %h expected %h", i, obs_sec[i], m_sec[i]); end
        end
        n_cmp++; if (spr0_in_line !== 1'b1) begin n_err++; $display("FAIL spr0_flag: got %b expected 1", spr0_in_line); end
        n_cmp++; if (spr_count !== 4'd1) begin n_err++; $display("FAIL spr0_count: got %0d expected 1", spr_count); end
        n_cmp++; if (obs_done_dot != exp_done) begin n_err++; $display("FAIL spr0_done_dot: got %0d expected %0d", obs_done_dot, exp_done); end
    endtask

    task automatic test_overflow();
        clear_oam();
        for (int i = 0; i < 10; i++) begin
            oam[4*i] = 8'd20;
            for (int b = 1; b < 4; b++) oam[4*i+b] = 8'($urandom);
        end
        model_line(20, 1'b1, 1'b0);
        run_line(20, 1'b1, 1'b0, 340, -1);
        read_sec();
        n_cmp++; if (spr_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", spr_overflow); end
        n_cmp++; if (spr_count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d expected 8", spr_count); end
        n_cmp++; if (obs_done_dot != exp_done) begin n_err++; $display("FAIL ovf_done_dot: got %0d expected %0d", obs_done_dot, exp_done); end
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (obs_sec[i] !== m_sec[i]) begin n_err++; $display("FAIL ovf_sec[%0d]: got %h expected %h", i, obs_sec[i], m_sec[i]); end
        end
        model_line(240, 1'b1, 1'b0);
        run_line(240, 1'b1, 1'b0, 340, -1);
        n_cmp++; if (spr_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", spr_overflow); end
        run_line(261, 1'b1, 1'b0, 0, -1);
        n_cmp++; if (spr_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pre_dot0: got %b expected 1", spr_overflow); end
        model_line(261, 1'b1, 1'b0);
        run_line(261, 1'b1, 1'b0, 340, -1);
        n_cmp++; if (spr_overflow !== m_ovf) begin n_err++; $display("FAIL ovf_cleared: got %b expected %b", spr_overflow, m_ovf); end
    endtask

    task automatic test_tall();
        int rows [3] = '{110, 110, 99};
        bit tall [3] = '{1'b0, 1'b1, 1'b1};
        clear_oam();
        oam[20] = 8'd100;
        oam[21] = 8'h5A;
        for (int t = 0; t < 3; t++) begin
            model_line(rows[t], 1'b1, tall[t]);
            run_line(rows[t], 1'b1, tall[t], 340, -1);
            read_sec();
            n_cmp++; if (spr_count !== 4'(m_cnt)) begin n_err++; $display("FAIL tall%0d_count: got %0d expected %0d", t, spr_count, m_cnt); end
            n_cmp++; if (obs_done_dot != exp_done) begin n_err++; $display("FAIL tall%0d_done_dot: got %0d expected %0d", t, obs_done_dot, exp_done); end
            n_cmp++; if (obs_sec[1] !== m_sec[1]) begin n_err++; $display("FAIL tall%0d_tile: got %h expected %h", t, obs_sec[1], m_sec[1]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_oam();
        oam[16] = 8'd12;
        oam[17] = 8'h33;
        run_line(12, 1'b1, 1'b0, 69, -1);
        @(negedge clk);
        col = 9'd70; clk_en = 1'b1;
        #1;
        n_cmp++; if (bus.eval_active !== 1'b1) begin n_err++; $display("FAIL rstmid_active: got %b expected 1", bus.eval_active); end
        n_cmp++; if (bus.oam_addr !== 8'd17) begin n_err++; $display("FAIL rstmid_oam_addr: got %0d expected 17", bus.oam_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; clk_en = 1'b0;
        #1;
        n_cmp++; if (bus.eval_active !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b expected 0", bus.eval_active); end
        n_cmp++; if (spr_count !== 4'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", spr_count); end
        n_cmp++; if (eval_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b expected 0", eval_done); end
        n_cmp++; if (bus.oam_addr !== 8'd0) begin n_err++; $display("FAIL rstmid_addr0: got %0d expected 0", bus.oam_addr); end
        read_sec();
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (obs_sec[i] !== 8'hFF) begin n_err++; $display("FAIL rstmid_sec[%0d]: got %h expected ff", i, obs_sec[i]); end
        end
        foreach (m_sec[b]) m_sec[b] = 8'hFF;
        m_cnt = 0; m_spr0 = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic test_inactive();
        clear_oam();
        oam[8] = 8'd28; oam[9] = 8'h11; oam[12] = 8'd28; oam[13] = 8'h22;
        model_line(30, 1'b1, 1'b0);
        run_line(30, 1'b1, 1'b0, 340, -1);
        for (int i = 0; i < 64; i++) begin
            oam[4*i] = 8'd30;
            oam[4*i+1] = 8'($urandom);
        end
        for (int t = 0; t < 2; t++) begin
            model_line(t == 0 ? 30 : 240, t != 0, t != 0);
            run_line(t == 0 ? 30 : 240, t != 0, t != 0, 340, -1);
            read_sec();
            n_cmp++; if (obs_act_cnt != 0) begin n_err++; $display("FAIL idle%0d_active: got %0d expected 0", t, obs_act_cnt); end
            n_cmp++; if (obs_done_cnt != 0) begin n_err++; $display("FAIL idle%0d_done: got %0d expected 0", t, obs_done_cnt); end
            n_cmp++; if (spr_count !== 4'(m_cnt)) begin n_err++; $display("FAIL idle%0d_count: got %0d expected %0d", t, spr_count, m_cnt); end
            for (int i = 0; i < 32; i++) begin
                n_cmp++; if (obs_sec[i] !== m_sec[i]) begin n_err++; $display("FAIL idle%0d_sec[%0d]: got %h expected %h", t, i, obs_sec[i], m_sec[i]); end
            end
        end
    endtask

    task automatic test_render_drop();
        int drops [2] = '{80, 64};
        int acts  [2] = '{16, 0};
        int cnts  [2] = '{2, 0};
        clear_oam();
        for (int s = 0; s < 2; s++) begin
            oam[4*s] = 8'd50;
            for (int b = 1; b < 4; b++) oam[4*s+b] = 8'($urandom);
        end
        for (int t = 0; t < 2; t++) begin
            foreach (m_sec[b]) m_sec[b] = 8'hFF;
            for (int b = 0; b < 4 * cnts[t]; b++) m_sec[b] = oam[b];
            m_cnt = cnts[t];
            m_spr0 = (cnts[t] > 0);
            run_line(50, 1'b1, 1'b0, 340, drops[t]);
            read_sec();
            n_cmp++; if (obs_act_cnt != acts[t]) begin n_err++; $display("FAIL drop%0d_active: got %0d expected %0d", t, obs_act_cnt, acts[t]); end
            n_cmp++; if (obs_done_cnt != 0) begin n_err++; $display("FAIL drop%0d_done: got %0d expected 0", t, obs_done_cnt); end
            n_cmp++; if (spr_count !== 4'(m_cnt)) begin n_err++; $display("FAIL drop%0d_count: got %0d expected %0d", t, spr_count, m_cnt); end
            n_cmp++; if (spr0_in_line !== m_spr0) begin n_err++; $display("FAIL drop%0d_spr0: got %b expected %b", t, spr0_in_line, m_spr0); end
            for (int i = 0; i < 32; i++) begin
                n_cmp++; if (obs_sec[i] !== m_sec[i]) begin n_err++; $display("FAIL drop%0d_sec[%0d]: got %h expected %h", t, i, obs_sec[i], m_sec[i]); end
            end
        end
    endtask

    task automatic test_random();
        for (int l = 0; l < 40; l++) begin
            int  r;
            int  dens;
            bit  rend;
            bit  s16;
            r    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(240, 261)) : int'($urandom_range(0, 239));
            rend = ($urandom_range(0, 7) != 0);
            s16  = 1'($urandom_range(0, 1));
            dens = int'($urandom_range(1, 6));
            for (int i = 0; i < 64; i++) begin
                int yy;
                if (int'($urandom_range(0, 15)) < dens) begin
                    yy = r - int'($urandom_range(0, 17));
                    if (yy < 0) yy = 255;
                end else begin
                    yy = int'($urandom_range(0, 255));
                end
                oam[4*i] = 8'(yy);
                for (int b = 1; b < 4; b++) oam[4*i+b] = 8'($urandom);
            end
            model_line(r, rend, s16);
            run_line(r, rend, s16, 340, -1);
            read_sec();
            n_cmp++; if (obs_done_dot != exp_done) begin n_err++; $display("FAIL rnd%0d_done_dot: got %0d expected %0d (row %0d)", l, obs_done_dot, exp_done, r); end
            n_cmp++; if (obs_done_cnt != (exp_done < 0 ? 0 : 1)) begin n_err++; $display("FAIL rnd%0d_done_pulses: got %0d", l, obs_done_cnt); end
            n_cmp++; if (obs_act_cnt != (exp_done < 0 ? 0 : exp_done - 65)) begin n_err++; $display("FAIL rnd%0d_active: got %0d", l, obs_act_cnt); end
            n_cmp++; if (spr_count !== 4'(m_cnt)) begin n_err++; $display("FAIL rnd%0d_count: got %0d expected %0d", l, spr_count, m_cnt); end
            n_cmp++; if (spr0_in_line !== m_spr0) begin n_err++; $display("FAIL rnd%0d_spr0: got %b expected %b", l, spr0_in_line, m_spr0); end
            n_cmp++; if (spr_overflow !== m_ovf) begin n_err++; $display("FAIL rnd%0d_ovf: got %b expected %b", l, spr_overflow, m_ovf); end
            for (int i = 0; i < 32; i++) begin
                n_cmp++; if (obs_sec[i] !== m_sec[i]) begin n_err++; $display("FAIL rnd%0d_sec[%0d]: got %h expected %h", l, i, obs_sec[i], m_sec[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_miss();
        test_sprite0();
        test_overflow();
        test_tall();
        test_reset_mid();
        test_inactive();
        test_render_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
